// File: rtl/status_reg.sv
// Processor status register: holds N,V,D,I,Z,C. It applies ALU flag updates
// one cycle after they are issued, and also handles PLP/RTI loads and the
// explicit set/clear flag instructions. It builds the pushed P image and
// qualifies interrupt requests.
module status_reg (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       RDY,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_mode,
  input  logic       alu_co,
  input  logic       alu_v,
  input  logic       alu_z,
  input  logic       alu_n,
  input  logic [7:0] DB,
  input  logic       load_p,
  input  logic       flag_en,
  input  logic [2:0] flag_sel,
  input  logic       brk,
  input  logic       irq,
  output logic       C,
  output logic       Z,
  output logic       I,
  output logic       D,
  output logic       V,
  output logic       N,
  output logic [7:0] p_push,
  output logic       irq_take
);

  // Requests captured at issue. The ALU flags they refer to arrive one cycle later.
  logic pend_nz_q, pend_c_q, pend_v_q, pend_bit_q;
  logic c_q, z_q, i_q, d_q, v_q, n_q;
  logic c_d, z_d, i_d, d_d, v_d, n_d;
  logic irq_take_q;

  // DB[5:4] have no flag behind them. The B and unused bits exist only in the pushed image.
  logic db_unused;
  assign db_unused = &{1'b0, DB[5:4]};

  // Next flag values. Each step may overwrite the one before it, so the
  // priority per bit is: load_p, then the pending ALU update, then flag_sel.
  always_comb begin
    c_d = c_q;
    z_d = z_q;
    i_d = i_q;
    d_d = d_q;
    v_d = v_q;
    n_d = n_q;

    if (flag_en) begin
      case (flag_sel)
        3'd0: c_d = 1'b0;
        3'd1: c_d = 1'b1;
        3'd2: i_d = 1'b0;
        3'd3: i_d = 1'b1;
        3'd4: d_d = 1'b0;
        3'd5: d_d = 1'b1;
        3'd6: v_d = 1'b0;
        default: ;
      endcase
    end

    if (pend_nz_q) begin
      n_d = alu_n;
      z_d = alu_z;
    end
    if (pend_c_q) c_d = alu_co;
    if (pend_v_q) v_d = alu_v;
    // BIT takes N and V from memory and Z from the AND result. It overrides any nz/v update.
    if (pend_bit_q) begin
      n_d = DB[7];
      v_d = DB[6];
      z_d = alu_z;
    end

    if (load_p) begin
      n_d = DB[7];
      v_d = DB[6];
      d_d = DB[3];
      i_d = DB[2];
      z_d = DB[1];
      c_d = DB[0];
    end
  end

  // Flag, pending and irq state. Reset always wins. When RDY is low, everything holds.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pend_nz_q  <= 1'b0;
      pend_c_q   <= 1'b0;
      pend_v_q   <= 1'b0;
      pend_bit_q <= 1'b0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      i_q        <= 1'b1;
      d_q        <= 1'b0;
      v_q        <= 1'b0;
      n_q        <= 1'b0;
      irq_take_q <= 1'b0;
    end else if (RDY) begin
      pend_nz_q  <= upd_nz;
      pend_c_q   <= upd_c;
      pend_v_q   <= upd_v;
      pend_bit_q <= bit_mode;
      c_q        <= c_d;
      z_q        <= z_d;
      i_q        <= i_d;
      d_q        <= d_d;
      v_q        <= v_d;
      n_q        <= n_d;
      irq_take_q <= irq & ~i_q;
    end
  end

  assign C        = c_q;
  assign Z        = z_q;
  assign I        = i_q;
  assign D        = d_q;
  assign V        = v_q;
  assign N        = n_q;
  assign irq_take = irq_take_q;
  assign p_push   = {n_q, v_q, 1'b1, brk, d_q, i_q, z_q, c_q};

endmodule

// File: tb/tb_status_reg.sv
// Directed bench for status_reg. Inputs are driven and outputs are sampled on
// the falling edge. Expected flag vectors {N,V,D,I,Z,C} are written by hand.
module tb_status_reg;

  logic       clk = 1'b0;
  logic       reset_n, RDY, upd_nz, upd_c, upd_v, bit_mode;
  logic       alu_co, alu_v, alu_z, alu_n;
  logic [7:0] DB;
  logic       load_p, flag_en;
  logic [2:0] flag_sel;
  logic       brk, irq;
  logic       C, Z, I, D, V, N, irq_take;
  logic [7:0] p_push;
  logic [5:0] fl;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  status_reg dut (
    .clk(clk), .reset_n(reset_n), .RDY(RDY),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_mode(bit_mode),
    .alu_co(alu_co), .alu_v(alu_v), .alu_z(alu_z), .alu_n(alu_n),
    .DB(DB), .load_p(load_p), .flag_en(flag_en), .flag_sel(flag_sel),
    .brk(brk), .irq(irq),
    .C(C), .Z(Z), .I(I), .D(D), .V(V), .N(N),
    .p_push(p_push), .irq_take(irq_take)
  );

  assign fl = {N, V, D, I, Z, C};

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    upd_nz = 0; upd_c = 0; upd_v = 0; bit_mode = 0;
    alu_co = 0; alu_v = 0; alu_z = 0; alu_n = 0;
    DB = 8'h00; load_p = 0; flag_en = 0; flag_sel = 3'd7;
  endtask

  logic [2:0] sel_tab [8];
  logic [5:0] exp_tab [8];

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sel_tab = '{3'd5, 3'd7, 3'd6, 3'd4, 3'd2, 3'd3, 3'd0, 3'd1};
    exp_tab = '{6'b111111, 6'b111111, 6'b101111, 6'b100111,
                6'b100011, 6'b100111, 6'b100110, 6'b100111};

    idle();
    brk = 0; irq = 0;
    // Reset is asserted with RDY low, so it must not depend on RDY.
    reset_n = 0; RDY = 0;
    @(negedge clk);
    tick();
    chk("reset_flags_rdy_low", {2'b0, fl}, 8'b00_000100);
    RDY = 1;
    tick();
    reset_n = 1;
    chk("reset_flags", {2'b0, fl}, 8'b00_000100);
    chk("reset_irq_take", {7'b0, irq_take}, 8'h00);
    chk("reset_p_push", p_push, 8'h24);

    // upd_nz + upd_c: the flags change only on the second edge.
    upd_nz = 1; upd_c = 1;
    tick();
    idle();
    chk("nzc_issue_edge", {2'b0, fl}, 8'b00_000100);
    alu_n = 1; alu_z = 0; alu_co = 1;
    tick();
    idle();
    chk("nzc_apply", {2'b0, fl}, 8'b00_100101);

    // BIT: N,V come from DB and Z from the ALU. C is untouched.
    bit_mode = 1;
    tick();
    idle();
    DB = 8'hC0; alu_z = 1;
    tick();
    idle();
    chk("bit_apply", {2'b0, fl}, 8'b00_110111);
    // Nothing is pending now, so changing the ALU inputs has no effect.
    alu_n = 0; alu_z = 0; alu_co = 0; alu_v = 0; DB = 8'h00;
    tick();
    chk("pending_cleared", {2'b0, fl}, 8'b00_110111);

    // Stall: clear C, issue upd_c, hold RDY low for 3 cycles, then apply.
    flag_en = 1; flag_sel = 3'd0;
    tick();
    idle();
    chk("clc", {2'b0, fl}, 8'b00_110110);
    upd_c = 1;
    tick();
    idle();
    RDY = 0; flag_en = 1; flag_sel = 3'd5;
    for (int k = 0; k < 3; k++) tick();
    chk("stall_hold", {2'b0, fl}, 8'b00_110110);
    idle();
    RDY = 1; alu_co = 1;
    tick();
    idle();
    chk("stall_release_c", {2'b0, fl}, 8'b00_110111);

    // Sweep through every flag_sel code, including the no-op.
    for (int k = 0; k < 8; k++) begin
      flag_en = 1; flag_sel = sel_tab[k];
      tick();
      chk($sformatf("flag_sel%0d", sel_tab[k]), {2'b0, fl}, {2'b0, exp_tab[k]});
    end
    idle();

    // load_p ignores DB[5:4].
    load_p = 1; DB = 8'h3A;
    tick();
    idle();
    chk("load_p", {2'b0, fl}, 8'b00_001010);
    chk("load_p_push", p_push, 8'h2A);

    // On the same edge, load_p beats the pending C update and SEI.
    upd_c = 1;
    tick();
    idle();
    load_p = 1; DB = 8'h00; alu_co = 1; flag_en = 1; flag_sel = 3'd3;
    tick();
    idle();
    chk("load_priority", {2'b0, fl}, 8'b00_000000);
    brk = 1;
    #1;
    chk("p_push_brk", p_push, 8'h30);
    brk = 0;

    // The pending V update and SEC touch different bits, so both apply.
    upd_v = 1;
    tick();
    idle();
    alu_v = 1; flag_en = 1; flag_sel = 3'd1;
    tick();
    idle();
    chk("merge_v_sec", {2'b0, fl}, 8'b00_010001);

    // irq_take uses the I value from before the edge.
    flag_en = 1; flag_sel = 3'd3;
    tick();
    idle();
    irq = 1; flag_en = 1; flag_sel = 3'd2;
    tick();
    idle();
    chk("cli_i", {7'b0, I}, 8'h00);
    chk("cli_irq_take_late", {7'b0, irq_take}, 8'h00);
    tick();
    chk("irq_take", {7'b0, irq_take}, 8'h01);
    irq = 0;
    tick();
    chk("irq_take_drop", {7'b0, irq_take}, 8'h00);

    // Reset discards a pending nz update.
    upd_nz = 1;
    tick();
    idle();
    reset_n = 0; alu_n = 1; alu_z = 1;
    tick();
    reset_n = 1;
    tick();
    idle();
    chk("reset_discard", {2'b0, fl}, 8'b00_000100);
    chk("reset_discard_irq", {7'b0, irq_take}, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/status_reg.md
STATUS_REG -- requirements
Module: status_reg

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: RDY  input  1  clock enable; when low, no state changes except reset.
REQ-004 SHALL have port: upd_nz  input  1  issue-cycle request: update N,Z from the ALU result.
REQ-005 SHALL have port: upd_c  input  1  issue-cycle request: update C from the ALU CO.
REQ-006 SHALL have port: upd_v  input  1  issue-cycle request: update V from the ALU V.
REQ-007 SHALL have port: bit_mode  input  1  issue-cycle request: BIT semantics (N,V from DB[7:6]; Z from ALU).
REQ-008 SHALL have port: alu_co, alu_v, alu_z, alu_n  input  1 each  registered ALU flags, valid the cycle after issue.
REQ-009 SHALL have port: DB  input  8  data bus, used by load_p and bit_mode.
REQ-010 SHALL have port: load_p  input  1  load P from DB (PLP/RTI).
REQ-011 SHALL have port: flag_en  input  1  execute flag_sel.
REQ-012 SHALL have port: flag_sel  input  3  0 CLC, 1 SEC, 2 CLI, 3 SEI, 4 CLD, 5 SED, 6 CLV, 7 no-op.
REQ-013 SHALL have port: brk  input  1  B-bit value for the pushed image.
REQ-014 SHALL have port: irq  input  1  level interrupt request.
REQ-015 SHALL have port: C, Z, I, D, V, N  output  1 each  current flags; C feeds ALU CI, D feeds ALU BCD.
REQ-016 SHALL have port: p_push  output  8  {N,V,1,brk,D,I,Z,C}, combinational.
REQ-017 SHALL have port: irq_take  output  1  registered irq & ~I.

Function
REQ-018 SHALL capture {upd_nz,upd_c,upd_v,bit_mode} into a one-stage pending register on each RDY-high edge; the pending register SHALL be cleared when the sampled requests are all zero.
REQ-019 SHALL apply a pending update on the next RDY-high edge, using alu_* and DB in that cycle; flags visible two edges after issue.
REQ-020 SHALL freeze the pending register and all flags while RDY low; stalled requests SHALL apply on the first RDY-high edge with the ALU values present then.
REQ-021 Pending nz: N<=alu_n, Z<=alu_z; pending c: C<=alu_co; pending v: V<=alu_v.
REQ-022 Pending bit_mode: N<=DB[7], V<=DB[6], Z<=alu_z; it overrides nz/v for N,V and leaves C untouched unless c also pending.
REQ-023 load_p SHALL set {N,V,D,I,Z,C} from DB bits {7,6,3,2,1,0} at the next RDY-high edge; DB[5:4] ignored.
REQ-024 flag_en SHALL modify only the selected flag at the next RDY-high edge; flag_sel 7 SHALL change nothing.
REQ-025 Priority per bit on the same edge: load_p > pending ALU update > flag_sel; non-overlapping bits from lower-priority sources SHALL still apply.
REQ-026 irq_take SHALL register irq & ~I using the I value before the edge, updated on RDY-high edges.
REQ-027 p_push bit 5 SHALL always be 1; bit 4 SHALL equal brk combinationally.

Reset
REQ-028 On a reset_n-low edge, regardless of RDY: N=0, V=0, D=0, I=1, Z=0, C=0, pending cleared, irq_take=0.
REQ-029 Reset during a pending update SHALL discard it; the first post-reset edge SHALL apply nothing from before reset.

Verification
REQ-030 Reset, then upd_nz+upd_c at T with alu_n=1, alu_z=0, alu_co=1 at T+1 -> N=1, Z=0, C=1 after edge T+2; V=0, I=1 unchanged.
REQ-031 bit_mode at T, DB=8'hC0, alu_z=1 at T+1 -> N=1, V=1, Z=1 after T+2; C unchanged.
REQ-032 upd_c at T, RDY low T+1..T+3, alu_co=1 only when RDY returns at T+4 -> C=1 after edge T+4, C unchanged before.
REQ-033 Same edge: load_p with DB=8'h00, pending upd_c with alu_co=1, flag_en SEI -> all flags 0 (load wins on C and I).
REQ-034 CLI via flag_en, irq=1 held -> I=0 one edge later; irq_take=1 one edge after that; p_push with brk=1, flags 0 = 8'h30.
REQ-035 Issue upd_nz, assert reset_n low next cycle, release -> flags at reset values; no late N/Z update.
